// File: rtl/quad_decoder.sv
// Rotary encoder front end: two-flop sync and debounce on cha/chb/sw, x4 quadrature
// decode with detent accumulation, wrapping position count, press pulse and error flag.
module quad_decoder #(
  parameter int unsigned BOUNCE_LIMIT     = 100000,
  parameter int unsigned STEPS_PER_DETENT = 4,
  parameter int unsigned POS_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cha_i,
  input  logic                 chb_i,
  input  logic                 sw_i,
  output logic                 step_o,
  output logic                 dir_o,
  output logic [POS_WIDTH-1:0] position_o,
  output logic                 press_o,
  output logic                 sw_level_o,
  output logic                 err_o
);

  localparam int unsigned NCH    = 3;
  localparam int unsigned IDX_B  = 0;
  localparam int unsigned IDX_A  = 1;
  localparam int unsigned IDX_SW = 2;
  localparam int unsigned CNT_W  = (BOUNCE_LIMIT > 1) ? $clog2(BOUNCE_LIMIT) : 1;
  localparam int unsigned ACC_W  = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOUNCE_LIMIT - 1);
  localparam int               ACC_LIM = int'(STEPS_PER_DETENT) - 1;
  // acc is compared one transition early so +STEPS never has to be stored in 3 bits
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(ACC_LIM);
  localparam logic signed [ACC_W-1:0] ACC_BOT = ACC_W'(-ACC_LIM);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync2_q;
  logic [NCH-1:0] filt_q, filt_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]                 prev_q;
  logic [1:0]                 cur_ab;
  logic                       sw_prev_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       step_q, step_d;
  logic                       dir_q, dir_d;
  logic [POS_WIDTH-1:0]       pos_q, pos_d;
  logic                       press_q, press_d;
  logic                       err_q, err_d;
  logic                       cw, ccw, both, rise;

  assign raw = {sw_i, cha_i, chb_i};

  // Metastability synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-input debounce: accept a new level after BOUNCE_LIMIT consecutive differing cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cur_ab = {filt_q[IDX_A], filt_q[IDX_B]};
  assign both   = (cur_ab ^ prev_q) == 2'b11;
  assign rise   = filt_q[IDX_SW] & ~sw_prev_q;

  // Gray-code transition classification on {A,B}
  always_comb begin
    cw  = 1'b0;
    ccw = 1'b0;
    case ({prev_q, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: cw  = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: ccw = 1'b1;
      default: ;
    endcase
  end

  // Detent accumulation; a press overrides a simultaneous step
  always_comb begin
    acc_d   = acc_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    press_d = rise;
    err_d   = both;
    if (both) begin
      acc_d = '0;
    end else if (cw) begin
      if (acc_q == ACC_TOP) begin
        acc_d  = '0;
        step_d = 1'b1;
        dir_d  = 1'b1;
        pos_d  = pos_q + POS_WIDTH'(1);
      end else begin
        acc_d = acc_q + 3'sd1;
      end
    end else if (ccw) begin
      if (acc_q == ACC_BOT) begin
        acc_d  = '0;
        step_d = 1'b1;
        dir_d  = 1'b0;
        pos_d  = pos_q - POS_WIDTH'(1);
      end else begin
        acc_d = acc_q - 3'sd1;
      end
    end
    if (rise) begin
      acc_d  = '0;
      step_d = 1'b0;
      dir_d  = dir_q;
      pos_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 2'b00;
      sw_prev_q <= 1'b0;
      acc_q     <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pos_q     <= '0;
      press_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= cur_ab;
      sw_prev_q <= filt_q[IDX_SW];
      acc_q     <= acc_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      press_q   <= press_d;
      err_q     <= err_d;
    end
  end

  assign step_o     = step_q;
  assign dir_o      = dir_q;
  assign position_o = pos_q;
  assign press_o    = press_q;
  assign sw_level_o = filt_q[IDX_SW];
  assign err_o      = err_q;

endmodule
